// File: rtl/axis_uart_rx.sv
// UART receiver (1 start, DATA_WIDTH data bits LSB first, 1 stop) presenting
// each received word on an AXI4-Stream master port, with line-status pulses.
module axis_uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  rxd,
  output logic                  rx_busy,
  output logic                  rx_overrun_error,
  output logic                  rx_frame_error,
  input  logic [15:0]           prescale
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_sync1, r_sync2;
  logic [15:0]           r_p;
  logic [18:0]           r_cnt, w_cnt_nxt;
  logic [3:0]            r_idx, w_idx_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid, r_ovr, r_ferr;

  logic                  w_rxd_s;
  logic [15:0]           w_p_in;
  logic [18:0]           w_half_load, w_bit_load;
  logic                  w_capture, w_shift_en, w_deliver, w_ferr;

  assign w_rxd_s     = r_sync2;
  assign w_p_in      = (prescale == 16'd0) ? 16'd1 : prescale;
  // Half a bit period from the falling edge lands the first sample mid-bit.
  assign w_half_load = {1'b0, w_p_in, 2'b00} - 19'd1;
  assign w_bit_load  = {r_p, 3'b000} - 19'd1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    w_shift_en  = 1'b0;
    w_deliver   = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxd_s) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = w_half_load;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_cnt == 19'd0) begin
          if (!w_rxd_s) begin
            w_cnt_nxt   = w_bit_load;
            w_idx_nxt   = 4'd0;
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 19'd1;
        end
      end
      S_DATA: begin
        if (r_cnt == 19'd0) begin
          w_shift_en = 1'b1;
          w_cnt_nxt  = w_bit_load;
          if (r_idx == 4'(DATA_WIDTH - 1)) w_state_nxt = S_STOP;
          else                              w_idx_nxt   = r_idx + 4'd1;
        end else begin
          w_cnt_nxt = r_cnt - 19'd1;
        end
      end
      S_STOP: begin
        if (r_cnt == 19'd0) begin
          if (w_rxd_s) begin
            w_deliver   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_WAIT_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 19'd1;
        end
      end
      S_WAIT_IDLE: begin
        // A held-low line (break) reports once, then waits for the line to recover.
        if (w_rxd_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_p      <= 16'd0;
      r_cnt    <= 19'd0;
      r_idx    <= 4'd0;
      r_shift  <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_ovr    <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_ferr  <= w_ferr;
      r_ovr   <= w_deliver && r_tvalid && !m_axis_tready;
      if (w_capture)  r_p     <= w_p_in;
      if (w_shift_en) r_shift <= {w_rxd_s, r_shift[DATA_WIDTH-1:1]};
      // A new word always wins; an unaccepted old word is overwritten.
      if (w_deliver) begin
        r_tdata  <= r_shift;
        r_tvalid <= 1'b1;
      end else if (r_tvalid && m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata     = r_tdata;
  assign m_axis_tvalid    = r_tvalid;
  assign rx_busy          = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
  assign rx_overrun_error = r_ovr;
  assign rx_frame_error   = r_ferr;

endmodule

// File: doc/axis_uart_rx.md
Name: axis_uart_rx

Overview:
- UART receiver that deserializes an asynchronous serial line (rxd) and presents each received word on an AXI4-Stream master port (m_axis_*).
- Forms the receive side of the UART build of the stream environment, complementing the stream-to-UART transmit path.
- Frame format: 8N1-style (1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit, no parity).
- Reports line status (busy, frame error, overrun).

Parameters:
DATA_WIDTH, 8, data bits per frame and m_axis_tdata width; legal range 5..9

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
m_axis_tdata  output  DATA_WIDTH  received word
m_axis_tvalid  output  1  received word available
m_axis_tready  input  1  downstream accepts word
rxd  input  1  serial line, idle high, asynchronous to clk
rx_busy  output  1  frame reception in progress
rx_overrun_error  output  1  one-cycle pulse: word dropped/overwritten
rx_frame_error  output  1  one-cycle pulse: stop bit sampled low
prescale  input  16  clocks per bit divided by 8 (bit period = 8*P clocks; P = prescale, 0 treated as 1)

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset effects: state=IDLE; all outputs 0 (tdata=0, tvalid=0, busy=0, both error pulses=0); both synchronizer flops=1; counters=0.
  - Reset mid-frame abandons the frame with no output and no error.
- rxd passes through a 2-flop synchronizer; rxd_s denotes the synchronized value. All sampling uses rxd_s.
- P is captured at start detection and held for the whole frame. Changing prescale mid-frame has no effect on the current frame.
- Bit counter: 19 bits; loads 4P-1 or 8P-1 and decrements to 0.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when rxd_s==0, load cnt=4P-1, go to START.
  - START: decrement cnt. When cnt==0:
    - rxd_s==0: load cnt=8P-1, bit_idx=0, go to DATA.
    - rxd_s==1: false start (glitch); go to IDLE with no error.
  - DATA: when cnt==0, shift rxd_s into the MSB of the shift register (right shift, so LSB arrives first) and reload cnt=8P-1.
    - If bit_idx==DATA_WIDTH-1, go to STOP; else increment bit_idx.
  - STOP: when cnt==0:
    - rxd_s==1: deliver the word (see output rules) and go to IDLE.
    - rxd_s==0: pulse rx_frame_error for 1 cycle, discard the word, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxd_s==1, then go to IDLE. A break condition yields exactly one frame error, not repeated errors.
- rx_busy = 1 in START, DATA and STOP; 0 otherwise.
- Sampling point: mid-bit.
- Latency: count the clk edge that first registers rxd=0 into the synchronizer as edge 0. m_axis_tvalid is 1 after edge 8P*(DATA_WIDTH+1)+4P+2.
- Output handshake rules:
  - Transfer occurs on any cycle with tvalid && tready.
  - tvalid stays high and tdata stays stable until transfer. The only exception is an overrun.
  - On word delivery:
    - tvalid==0, or tvalid && tready in the same cycle: load tdata, set tvalid=1, no error.
    - tvalid && !tready: overwrite tdata with the new word, keep tvalid=1, pulse rx_overrun_error for 1 cycle.
  - tvalid clears on the transfer cycle unless a new word is delivered in that same cycle.
- Back-to-back frames: a start bit immediately after a stop sample is detected normally. The start-bit search resumes from IDLE on the cycle after the stop sample.

Test Plan:
- Basic receive: DATA_WIDTH=8, prescale=1, tready=1; drive 0xA5 (bit period 8 clks) → tvalid high after edge 78, tdata=0xA5, single-cycle transfer; rx_busy high during the frame; no error pulses.
- Backpressure/overrun: tready=0; send 0x3C then 0xC3 → after frame 1, tvalid=1, tdata=0x3C; after frame 2, tdata=0xC3 and one rx_overrun_error pulse. Then raise tready → one transfer of 0xC3, tvalid=0.
- Frame error and break: send 0x55 with stop bit 0, then hold rxd low 40 bit periods, then release → exactly one rx_frame_error pulse, no tvalid; next frame 0x12 received correctly.
- Glitch rejection: prescale=4; pulse rxd low for 10 clks → state returns to IDLE, rx_busy drops, no tvalid, no errors.
- Prescale/back-to-back: prescale=3; send 0x00, 0xFF, 0x81 with no idle gap → three words in order, tdata sequence 0x00, 0xFF, 0x81; tvalid for word 1 after edge 8*3*9+12+2=230.
- Reset mid-frame: assert rst for 1 cycle halfway through the data bits of 0x77 → all outputs 0 the next cycle, no word delivered; subsequent 0x99 received correctly.
